// File: rtl/riscv64g_iss_csr_exec.sv
// Zicsr execute unit: sequenced read-modify-write on the CSR file, old value returned to writeback.
// Optional macro RISCV64G_ISS_CSR_RO_CHECK_EN makes CSRs at 0xC00-0xFFF reject writes as illegal.
module riscv64g_iss_csr_exec #(
  parameter int XLEN   = 64,
  parameter int ADDR_W = 12
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              REQ_VALID,
  output logic              REQ_READY,
  input  logic [2:0]        REQ_FUNCT3,
  input  logic [ADDR_W-1:0] REQ_CSR,
  input  logic [XLEN-1:0]   REQ_RS1_VAL,
  input  logic [4:0]        REQ_RS1_IDX,
  input  logic [4:0]        REQ_RD,
  output logic              CSR_WE,
  output logic [ADDR_W-1:0] CSR_A,
  input  logic [XLEN-1:0]   CSR_RD,
  output logic [XLEN-1:0]   CSR_WD,
  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [4:0]        RSP_RD,
  output logic              RSP_WE,
  output logic [XLEN-1:0]   RSP_DATA,
  output logic              RSP_ILLEGAL
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  state_t          state;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val;
  logic [4:0]      rs1_idx;

  logic [XLEN-1:0] operand;
  logic [XLEN-1:0] new_val;
  logic            write_en;
  logic            illegal;

  // Set/clear forms only write when rs1 names a register other than x0, regardless of its value.
  always_comb begin
    operand  = funct3[2] ? {{(XLEN-5){1'b0}}, rs1_idx} : rs1_val;
    new_val  = operand;
    write_en = 1'b0;
    illegal  = 1'b0;
    case (funct3[1:0])
      2'b01: write_en = 1'b1;
      2'b10: begin
        new_val  = CSR_RD | operand;
        write_en = (rs1_idx != 5'd0);
      end
      2'b11: begin
        new_val  = CSR_RD & ~operand;
        write_en = (rs1_idx != 5'd0);
      end
      default: illegal = 1'b1;
    endcase
`ifdef RISCV64G_ISS_CSR_RO_CHECK_EN
    if (write_en && (CSR_A[ADDR_W-1:ADDR_W-2] == 2'b11))
      illegal = 1'b1;
`else
`endif
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state       <= IDLE;
      REQ_READY   <= 1'b1;
      CSR_WE      <= 1'b0;
      CSR_A       <= '0;
      CSR_WD      <= '0;
      RSP_VALID   <= 1'b0;
      RSP_RD      <= '0;
      RSP_WE      <= 1'b0;
      RSP_DATA    <= '0;
      RSP_ILLEGAL <= 1'b0;
      funct3      <= '0;
      rs1_val     <= '0;
      rs1_idx     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (REQ_VALID) begin
            funct3    <= REQ_FUNCT3;
            CSR_A     <= REQ_CSR;
            rs1_val   <= REQ_RS1_VAL;
            rs1_idx   <= REQ_RS1_IDX;
            RSP_RD    <= REQ_RD;
            REQ_READY <= 1'b0;
            state     <= READ;
          end
        end
        READ: begin
          RSP_DATA    <= CSR_RD;
          RSP_ILLEGAL <= illegal;
          RSP_WE      <= (RSP_RD != 5'd0) && !illegal;
          CSR_WE      <= write_en && !illegal;
          CSR_WD      <= new_val;
          state       <= WRITE;
        end
        WRITE: begin
          CSR_WE    <= 1'b0;
          RSP_VALID <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            REQ_READY <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv64g_iss_csr_exec.sv
// Self-checking bench for riscv64g_iss_csr_exec: directed plan cases plus randomized CSR ops against a rule-level model.
module tb_riscv64g_iss_csr_exec;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [2:0]  REQ_FUNCT3;
  logic [11:0] REQ_CSR;
  logic [63:0] REQ_RS1_VAL;
  logic [4:0]  REQ_RS1_IDX;
  logic [4:0]  REQ_RD;
  logic        CSR_WE;
  logic [11:0] CSR_A;
  logic [63:0] CSR_RD;
  logic [63:0] CSR_WD;
  logic        RSP_VALID;
  logic        RSP_READY;
  logic [4:0]  RSP_RD;
  logic        RSP_WE;
  logic [63:0] RSP_DATA;
  logic        RSP_ILLEGAL;

  logic [63:0] csr_file [0:4095];
  int          vectors = 0;
  int          miscompares = 0;
  int          we_count = 0;

  riscv64g_iss_csr_exec #(.XLEN(64), .ADDR_W(12)) dut (
    .CLK(CLK), .RSTn(RSTn),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_FUNCT3(REQ_FUNCT3),
    .REQ_CSR(REQ_CSR), .REQ_RS1_VAL(REQ_RS1_VAL), .REQ_RS1_IDX(REQ_RS1_IDX),
    .REQ_RD(REQ_RD), .CSR_WE(CSR_WE), .CSR_A(CSR_A), .CSR_RD(CSR_RD),
    .CSR_WD(CSR_WD), .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
    .RSP_RD(RSP_RD), .RSP_WE(RSP_WE), .RSP_DATA(RSP_DATA), .RSP_ILLEGAL(RSP_ILLEGAL)
  );

  always #5 CLK = ~CLK;

  // Bench-owned CSR file: combinational read, write on the clock edge while CSR_WE is high.
  assign CSR_RD = csr_file[CSR_A];
  always @(posedge CLK) begin
    if (RSTn && CSR_WE) begin
      csr_file[CSR_A] <= CSR_WD;
      we_count = we_count + 1;
    end
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    vectors = vectors + 1;
    if (actual !== expected) begin
      miscompares = miscompares + 1;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Called at the negedge of an idle cycle; returns at the negedge of the next idle cycle.
  task automatic applyStimulus(input logic [2:0] f3, input logic [11:0] csr, input logic [63:0] val,
                               input logic [4:0] idx, input logic [4:0] rd, input int hold);
    logic [63:0] old_v, opnd, exp_new, final_v;
    logic        wr, ill, do_wr;
    int          we_before;
    old_v = csr_file[csr];
    opnd  = f3[2] ? 64'(idx) : val;
    ill   = 1'b0;
    wr    = 1'b0;
    exp_new = opnd;
    if (f3 == 3'd1 || f3 == 3'd5) begin
      wr = 1'b1; exp_new = opnd;
    end else if (f3 == 3'd2 || f3 == 3'd6) begin
      wr = (idx != 0); exp_new = old_v | opnd;
    end else if (f3 == 3'd3 || f3 == 3'd7) begin
      wr = (idx != 0); exp_new = old_v & ~opnd;
    end else begin
      ill = 1'b1;
    end
`ifdef RISCV64G_ISS_CSR_RO_CHECK_EN
    if (wr && csr >= 12'hC00) ill = 1'b1;
`endif
    do_wr   = wr && !ill;
    final_v = do_wr ? exp_new : old_v;
    we_before = we_count;

    checkOutput("req_ready_idle", 64'(REQ_READY), 64'd1);
    REQ_VALID = 1'b1; REQ_FUNCT3 = f3; REQ_CSR = csr; REQ_RS1_VAL = val;
    REQ_RS1_IDX = idx; REQ_RD = rd; RSP_READY = (hold == 0);
    @(negedge CLK);
    REQ_VALID = 1'b0;
    checkOutput("read_req_ready", 64'(REQ_READY), 64'd0);
    checkOutput("read_csr_a", 64'(CSR_A), 64'(csr));
    checkOutput("read_csr_we", 64'(CSR_WE), 64'd0);
    @(negedge CLK);
    checkOutput("write_csr_we", 64'(CSR_WE), 64'(do_wr));
    if (do_wr) checkOutput("write_csr_wd", CSR_WD, exp_new);
    checkOutput("write_rsp_valid", 64'(RSP_VALID), 64'd0);
    @(negedge CLK);
    for (int i = 0; i <= hold; i++) begin
      if (i > 0) @(negedge CLK);
      checkOutput("rsp_valid", 64'(RSP_VALID), 64'd1);
      checkOutput("rsp_data", RSP_DATA, old_v);
      checkOutput("rsp_rd", 64'(RSP_RD), 64'(rd));
      checkOutput("rsp_we", 64'(RSP_WE), 64'((rd != 0) && !ill));
      checkOutput("rsp_illegal", 64'(RSP_ILLEGAL), 64'(ill));
      checkOutput("rsp_req_ready", 64'(REQ_READY), 64'd0);
      checkOutput("rsp_csr_we", 64'(CSR_WE), 64'd0);
      checkOutput("rsp_csr_a", 64'(CSR_A), 64'(csr));
    end
    RSP_READY = 1'b1;
    @(negedge CLK);
    checkOutput("done_rsp_valid", 64'(RSP_VALID), 64'd0);
    checkOutput("done_req_ready", 64'(REQ_READY), 64'd1);
    checkOutput("csr_we_pulses", 64'(we_count - we_before), 64'(do_wr));
    checkOutput("csr_file_value", csr_file[csr], final_v);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(REQ_READY), 64'd1);
    checkOutput({tag, "_csr_we"}, 64'(CSR_WE), 64'd0);
    checkOutput({tag, "_csr_a"}, 64'(CSR_A), 64'd0);
    checkOutput({tag, "_csr_wd"}, CSR_WD, 64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(RSP_VALID), 64'd0);
    checkOutput({tag, "_rsp_rd"}, 64'(RSP_RD), 64'd0);
    checkOutput({tag, "_rsp_we"}, 64'(RSP_WE), 64'd0);
    checkOutput({tag, "_rsp_data"}, RSP_DATA, 64'd0);
    checkOutput({tag, "_rsp_illegal"}, 64'(RSP_ILLEGAL), 64'd0);
  endtask

  logic [11:0] rnd_csr;
  logic [11:0] csr_pool [0:4];

  initial begin
    for (int a = 0; a < 4096; a++) csr_file[a] = {$urandom, $urandom};
    csr_pool[0] = 12'h340; csr_pool[1] = 12'h300; csr_pool[2] = 12'hC00;
    csr_pool[3] = 12'hF14; csr_pool[4] = 12'h7C0;
    RSTn = 1'b0; REQ_VALID = 1'b0; REQ_FUNCT3 = '0; REQ_CSR = '0; REQ_RS1_VAL = '0;
    REQ_RS1_IDX = '0; REQ_RD = '0; RSP_READY = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    checkResetState("reset");
    RSTn = 1'b1;
    @(negedge CLK);

    csr_file[12'h340] = 64'hAA;
    applyStimulus(3'b001, 12'h340, 64'h1234, 5'd7, 5'd5, 0);
    csr_file[12'h300] = 64'hF0;
    applyStimulus(3'b010, 12'h300, 64'h0F, 5'd3, 5'd6, 0);
    csr_file[12'h300] = 64'hF0;
    applyStimulus(3'b010, 12'h300, 64'h0F, 5'd0, 5'd6, 0);
    csr_file[12'h300] = 64'hFF;
    applyStimulus(3'b111, 12'h300, 64'h0, 5'h1F, 5'd0, 0);
    applyStimulus(3'b100, 12'h300, 64'h55, 5'd4, 5'd9, 5);
    applyStimulus(3'b000, 12'h340, 64'h55, 5'd4, 5'd9, 0);
    applyStimulus(3'b011, 12'h340, 64'h0, 5'd2, 5'd1, 0);
    csr_file[12'hF14] = 64'h0;
    applyStimulus(3'b001, 12'hF14, 64'hDEAD, 5'd8, 5'd3, 0);
    csr_file[12'hF14] = 64'h0;
    applyStimulus(3'b010, 12'hF14, 64'hBEEF, 5'd0, 5'd3, 1);

    // Reset in the WRITE cycle must kill the pending CSR write at once.
    csr_file[12'h340] = 64'h77;
    REQ_VALID = 1'b1; REQ_FUNCT3 = 3'b001; REQ_CSR = 12'h340; REQ_RS1_VAL = 64'h9999;
    REQ_RS1_IDX = 5'd1; REQ_RD = 5'd2; RSP_READY = 1'b1;
    @(negedge CLK);
    REQ_VALID = 1'b0;
    @(negedge CLK);
    checkOutput("prereset_csr_we", 64'(CSR_WE), 64'd1);
    #2 RSTn = 1'b0;
    #1 checkOutput("abort_csr_we", 64'(CSR_WE), 64'd0);
    @(negedge CLK);
    RSTn = 1'b1;
    checkResetState("abort");
    checkOutput("abort_csr_untouched", csr_file[12'h340], 64'h77);
    @(negedge CLK);
    checkResetState("abort_idle");

    for (int n = 0; n < 40; n++) begin
      rnd_csr = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095)) : csr_pool[$urandom_range(0, 4)];
      applyStimulus(3'($urandom_range(0, 7)), rnd_csr, {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                    int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/riscv64g_iss_csr_exec.md
Name: riscv64g_iss_csr_exec

Overview:
Executes RISC-V Zicsr instructions (CSRRW/S/C and immediate forms) for the ISS core. It is the initiator side of the CSR register-file port (WE/A/WD out, RD in). It accepts one decoded CSR request through a valid/ready handshake and performs a sequenced read-modify-write on the CSR file. It then returns the old CSR value to integer writeback through a second valid/ready handshake.

Parameters:
XLEN, 64, data width of CSR and GPR values
ADDR_W, 12, CSR address width

Ports:
CLK  in  1  clock
RSTn  in  1  reset, asynchronous, active-low
REQ_VALID  in  1  request valid
REQ_READY  out  1  request accepted when VALID&READY
REQ_FUNCT3  in  3  instruction funct3
REQ_CSR  in  ADDR_W  CSR address
REQ_RS1_VAL  in  XLEN  rs1 register value
REQ_RS1_IDX  in  5  rs1 index; doubles as zimm for the I-forms
REQ_RD  in  5  destination register index
CSR_WE  out  1  CSR file write enable
CSR_A  out  ADDR_W  CSR file address
CSR_RD  in  XLEN  CSR file combinational read data
CSR_WD  out  XLEN  CSR file write data
RSP_VALID  out  1  response valid
RSP_READY  in  1  response consumed when VALID&READY
RSP_RD  out  5  destination index
RSP_WE  out  1  GPR write required
RSP_DATA  out  XLEN  old CSR value
RSP_ILLEGAL  out  1  illegal-instruction indication

Behaviour:
- Reset (async, RSTn=0): state IDLE; REQ_READY=1; CSR_WE=0, CSR_A=0, CSR_WD=0; RSP_VALID=0, RSP_RD=0, RSP_WE=0, RSP_DATA=0, RSP_ILLEGAL=0. A reset in any state aborts the operation, and no CSR write follows.
- FSM states: IDLE, READ, WRITE, RESP.
  - IDLE: REQ_READY=1. On REQ_VALID, latch funct3, csr, rs1 value/idx and rd, then go to READ.
  - READ: CSR_A = latched csr; capture CSR_RD into old. Compute illegal/write_en/new. Go to WRITE.
  - WRITE: if write_en and not illegal, CSR_WE=1 for exactly this cycle with CSR_WD=new. Go to RESP.
  - RESP: RSP_VALID=1 and response fields stable. On RSP_READY go to IDLE. RSP_VALID must not drop before acceptance.
- REQ_READY=0 in every state except IDLE. Request-to-RSP_VALID latency is fixed at 3 cycles. Back-to-back requests give a throughput of 1 per 4 cycles when RSP_READY=1.
- CSR_A holds the latched address from READ through RESP. CSR_WE=0 outside WRITE.
- Operand: funct3[2]=1 selects zimm = zero-extended REQ_RS1_IDX; funct3[2]=0 selects rs1 value.
- New value:
  - 001/101: new = operand.
  - 010/110: new = old | operand.
  - 011/111: new = old & ~operand.
- write_en: 1 for 001/101. For 010/011/110/111, write_en = (REQ_RS1_IDX != 0), decided by the index and not the value. An rs1 value of 0 with a nonzero index still writes.
- illegal: funct3 of 000 or 100 gives illegal=1, no CSR write, RSP_WE=0, RSP_DATA=old.
- RSP_WE = (rd != 0) & ~illegal. RSP_RD = latched rd. RSP_DATA = old (the value before the write).

Optional Feature:
RISCV64G_ISS_CSR_RO_CHECK_EN
- Defined: a CSR with address bits [11:10]==2'b11 is read-only. An attempted write to it (write_en=1) sets illegal=1, suppresses CSR_WE and sets RSP_WE=0. A read-only access with write_en=0 (e.g. CSRRS with rs1 index 0) stays legal.
- Undefined: no address check; writes to 0xC00-0xFFF are issued like any other.

Test Plan:
- Reset, then CSRRW csr=0x340, rs1=0x1234, rd=5 (CSR holds 0xAA) -> CSR_WE=1 in cycle 2 with WD=0x1234; RSP_VALID in cycle 3 with RSP_DATA=0xAA, RSP_RD=5, RSP_WE=1.
- CSRRS csr=0x300 old=0xF0, rs1 idx=3 val=0x0F -> WD=0xFF. Same request with rs1 idx=0 -> no CSR_WE, RSP_DATA=0xF0.
- CSRRCI csr=0x300 old=0xFF, zimm=0x1F, rd=0 -> WD=0xE0; RSP_WE=0.
- funct3=100 -> no CSR_WE, RSP_ILLEGAL=1, RSP_WE=0. Hold RSP_READY=0 for 5 cycles -> RSP_VALID and data stable, REQ_READY=0 throughout.
- Assert RSTn=0 during WRITE -> CSR_WE=0 immediately; after release the block is in IDLE with all outputs at reset values.
- With RISCV64G_ISS_CSR_RO_CHECK_EN: CSRRW to 0xF14 -> RSP_ILLEGAL=1, no write. CSRRS 0xF14 with rs1 idx 0 -> legal, RSP_DATA=0.
